// File: rtl/st_unit.sv
// Store unit: latches an operand/address on start and writes it to memory
// over a four-phase req/ack handshake, reporting done or timeout error.
module st_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    input  logic [7:0] addr,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_wr,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dout,
    output logic       busy,
    output logic       done,
    output logic       err
);

    // state   | meaning
    // S_IDLE  | waiting for start; latches hold last transfer
    // S_SETUP | address/data stable, waiting for any old ack to drop
    // S_REQ   | mem_req/mem_wr high, timer running
    // S_REL   | req released, waiting for ack to drop
    // S_DONE  | one-cycle done pulse
    // S_ERR   | one-cycle err pulse after timeout
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_REQ,
        S_REL,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] tmr_q, tmr_d;
    logic [7:0] mem_addr_q, mem_addr_d;
    logic [7:0] mem_dout_q, mem_dout_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            mem_addr_q <= '0;
            mem_dout_q <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mem_addr_d = addr;
                    mem_dout_d = din;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!mem_ack) begin
                    tmr_d   = TMR_LOAD;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Timer counts down the req cycles remaining; zero is the last one.
                if (mem_ack) begin
                    state_d = S_REL;
                end else if (tmr_q == 8'd0) begin
                    state_d = S_ERR;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end
            S_REL: begin
                if (!mem_ack) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                // A late ack is drained so memory sees a clean release.
                state_d = mem_ack ? S_REL : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_req  = (state_q == S_REQ);
    assign mem_wr   = mem_req;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
    assign err      = (state_q == S_ERR);
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;

endmodule

// File: tb/tb_st_unit.sv
// Scoreboard bench for st_unit: instance a uses TIMEOUT=4, instance b TIMEOUT=3.
module tb_st_unit;

    logic       clk;
    logic       rst;
    logic       st_a, st_b;
    logic [7:0] din_a, din_b, addr_a, addr_b;
    logic       ack_a, ack_b;
    logic       req_a, req_b, wr_a, wr_b;
    logic [7:0] maddr_a, maddr_b, mdout_a, mdout_b;
    logic       busy_a, busy_b, done_a, done_b, err_a, err_b;

    typedef struct {
        bit         is_err;
        logic [7:0] addr;
        logic [7:0] data;
        int         req_cycles;
    } resp_t;

    resp_t q_a[$];
    resp_t q_b[$];
    int    req_cnt[2];
    int    vectors     = 0;
    int    miscompares = 0;

    st_unit #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .start(st_a), .din(din_a), .addr(addr_a),
        .mem_ack(ack_a), .mem_req(req_a), .mem_wr(wr_a), .mem_addr(maddr_a),
        .mem_dout(mdout_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    st_unit #(.TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .start(st_b), .din(din_b), .addr(addr_b),
        .mem_ack(ack_b), .mem_req(req_b), .mem_wr(wr_b), .mem_addr(maddr_b),
        .mem_dout(mdout_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int id, input bit is_err, input logic [7:0] a,
                        input logic [7:0] d, input int rc);
        resp_t e;
        e.is_err = is_err; e.addr = a; e.data = d; e.req_cycles = rc;
        if (id == 0) q_a.push_back(e);
        else         q_b.push_back(e);
    endtask

    task automatic score(input int id, input logic req, input logic dn, input logic er,
                         input logic [7:0] ma, input logic [7:0] md);
        resp_t e;
        if (req) req_cnt[id]++;
        if (dn && er) begin
            vectors++; miscompares++;
            $display("FAIL dut%0d_done_err_overlap: got done=1 err=1 expected exclusive", id);
        end
        if (dn || er) begin
            vectors++;
            if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
                miscompares++;
                $display("FAIL dut%0d_unexpected_resp: got done=%0b err=%0b expected none", id, dn, er);
            end else begin
                e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
                if (e.is_err != er || e.addr !== ma || e.data !== md || e.req_cycles != req_cnt[id]) begin
                    miscompares++;
                    $display("FAIL dut%0d_resp: got err=%0b addr=%h data=%h req=%0d expected err=%0b addr=%h data=%h req=%0d",
                             id, er, ma, md, req_cnt[id], e.is_err, e.addr, e.data, e.req_cycles);
                end
            end
            req_cnt[id] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            req_cnt[0] = 0;
            req_cnt[1] = 0;
        end else begin
            score(0, req_a, done_a, err_a, maddr_a, mdout_a);
            score(1, req_b, done_b, err_b, maddr_b, mdout_b);
        end
    end

    function automatic logic sel(input int s);
        case (s)
            0:       return req_a;
            1:       return busy_a;
            2:       return err_b;
            default: return busy_b;
        endcase
    endfunction

    // Bounded wait, sampled on negedges; an expired bound shows up as a failed check.
    task automatic wait_sig(input string name, input int s, input logic lvl);
        int n = 0;
        while (sel(s) !== lvl && n < 64) begin
            @(negedge clk);
            n++;
        end
        check(name, sel(s), lvl);
    endtask

    task automatic do_start(input int id, input logic [7:0] d, input logic [7:0] a);
        if (id == 0) begin din_a = d; addr_a = a; st_a = 1'b1; end
        else         begin din_b = d; addr_b = a; st_b = 1'b1; end
        @(negedge clk);
        st_a = 1'b0;
        st_b = 1'b0;
    endtask

    // Memory on port a: ack after `delay` cycles of req, drop it one cycle after req falls.
    task automatic mem_a(input int delay);
        wait_sig("a_req_rise", 0, 1'b1);
        check("a_wr_in_req", wr_a, 1'b1);
        repeat (delay - 1) @(negedge clk);
        ack_a = 1'b1;
        wait_sig("a_req_fall", 0, 1'b0);
        @(negedge clk);
        ack_a = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        st_a = 1'b0; st_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
        din_a = 8'h00; din_b = 8'h00; addr_a = 8'h00; addr_b = 8'h00;
        #1;
        check("reset_req", req_a, 1'b0);
        check("reset_busy", busy_a, 1'b0);
        check("reset_done", done_a, 1'b0);
        check("reset_err", err_a, 1'b0);
        check("reset_addr", maddr_a, 8'h00);
        check("reset_dout", mdout_a, 8'h00);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic write; inputs change after latching and must not matter.
        push(0, 1'b0, 8'h3C, 8'hA5, 2);
        do_start(0, 8'hA5, 8'h3C);
        din_a = 8'h00; addr_a = 8'hFF;
        check("basic_busy", busy_a, 1'b1);
        check("basic_addr", maddr_a, 8'h3C);
        check("basic_dout", mdout_a, 8'hA5);
        mem_a(2);
        wait_sig("basic_idle", 1, 1'b0);

        // Timeout with ack held low, then a normal store.
        push(0, 1'b1, 8'h10, 8'h44, 4);
        do_start(0, 8'h44, 8'h10);
        wait_sig("timeout_idle", 1, 1'b0);
        push(0, 1'b0, 8'h20, 8'h66, 2);
        do_start(0, 8'h66, 8'h20);
        mem_a(2);
        wait_sig("after_timeout_idle", 1, 1'b0);

        // Stuck ack before start.
        ack_a = 1'b1;
        push(0, 1'b0, 8'h5E, 8'hC3, 2);
        do_start(0, 8'hC3, 8'h5E);
        for (int i = 0; i < 4; i++) begin
            check("stuck_req", req_a, 1'b0);
            check("stuck_busy", busy_a, 1'b1);
            @(negedge clk);
        end
        ack_a = 1'b0;
        mem_a(2);
        wait_sig("stuck_idle", 1, 1'b0);

        // Start while busy is ignored.
        push(0, 1'b0, 8'h40, 8'h22, 2);
        do_start(0, 8'h22, 8'h40);
        wait_sig("busy_req_rise", 0, 1'b1);
        din_a = 8'h11; addr_a = 8'h41; st_a = 1'b1;
        @(negedge clk);
        st_a = 1'b0;
        ack_a = 1'b1;
        wait_sig("busy_req_fall", 0, 1'b0);
        @(negedge clk);
        ack_a = 1'b0;
        wait_sig("busy_idle", 1, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_no_second", busy_a, 1'b0);
        check("busy_dout_held", mdout_a, 8'h22);
        check("busy_addr_held", maddr_a, 8'h40);

        // Asynchronous reset while in REQ.
        do_start(0, 8'h5A, 8'h77);
        wait_sig("rst_req_rise", 0, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rst_req", req_a, 1'b0);
        check("rst_wr", wr_a, 1'b0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_done", done_a, 1'b0);
        check("rst_err", err_a, 1'b0);
        check("rst_addr", maddr_a, 8'h00);
        check("rst_dout", mdout_a, 8'h00);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push(0, 1'b0, 8'h00, 8'hFF, 2);
        do_start(0, 8'hFF, 8'h00);
        mem_a(2);
        wait_sig("rst_store_idle", 1, 1'b0);

        // Late ack arriving with err on the TIMEOUT=3 instance.
        push(1, 1'b1, 8'h9A, 8'h81, 3);
        push(1, 1'b0, 8'h9A, 8'h81, 0);
        do_start(1, 8'h81, 8'h9A);
        wait_sig("late_err", 2, 1'b1);
        ack_b = 1'b1;
        @(negedge clk);
        check("late_rel_req", req_b, 1'b0);
        check("late_rel_busy", busy_b, 1'b1);
        ack_b = 1'b0;
        wait_sig("late_idle", 3, 1'b0);

        repeat (3) @(negedge clk);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
